// File: rtl/cmd_sched_pkg.sv
// Shared constants and state encoding for the knight command scheduler.
// Optional feature macro: SQ_REPORT_EN adds the per-square REPORT state.
package cmd_sched_pkg;

    localparam logic [3:0] CMD_CAL     = 4'h0;
    localparam logic [3:0] CMD_MOVE    = 4'h2;
    localparam logic [3:0] CMD_MOVE_FF = 4'h3;

    localparam logic [7:0] RESP_CMPLT  = 8'hA5;
    localparam logic [7:0] RESP_INTER  = 8'h5A;

    localparam logic [9:0] FRWRD_INC   = 10'h010;
    localparam logic [9:0] FRWRD_DEC   = 10'h020;
    localparam logic [9:0] MAX_SPD     = 10'h300;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAL,
        ST_HDG,
        ST_RAMP,
        ST_DECEL,
`ifdef SQ_REPORT_EN
        ST_RESP,
        ST_REPORT
`else
        ST_RESP
`endif
    } state_t;

endpackage

// File: rtl/cmd_sched_frwrd_ramp.sv
// Forward-speed register: saturating ramp up to MAX_SPD and down to zero.
// Clear wins over increment, increment wins over decrement.
module frwrd_ramp
    import cmd_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_inc,
    input  logic       i_dec,
    input  logic       i_clr,
    output logic [9:0] o_frwrd
);

    logic [9:0] r_frwrd;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frwrd <= '0;
        end else if (i_clr) begin
            r_frwrd <= '0;
        end else if (i_inc) begin
            r_frwrd <= (r_frwrd >= MAX_SPD - FRWRD_INC) ? MAX_SPD : r_frwrd + FRWRD_INC;
        end else if (i_dec) begin
            r_frwrd <= (r_frwrd <= FRWRD_DEC) ? '0 : r_frwrd - FRWRD_DEC;
        end
    end

    assign o_frwrd = r_frwrd;

endmodule

// File: rtl/cmd_sched.sv
// Command scheduler: calibration or heading-then-forward move of N squares, one status byte back.
// Optional feature macro: SQ_REPORT_EN (0x5A report after each completed square except the last).
module cmd_sched
    import cmd_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    output logic        strt_cal,
    input  logic        cal_done,
    output logic [11:0] dsrd_hdg,
    input  logic        at_hdg,
    input  logic        cntrIR,
    output logic [9:0]  frwrd,
    output logic        moving,
    output logic        fanfare,
    output logic        send_resp,
    output logic [7:0]  resp,
    input  logic        resp_sent
);

    state_t      r_state;
    state_t      r_prev_state;
    state_t      w_next_state;
    logic [3:0]  r_op;
    logic [3:0]  r_sq;
    logic [4:0]  r_edge_cnt;
    logic        r_ir_prev;
    logic [11:0] r_hdg;
    logic [7:0]  r_resp;

    logic        w_cnt_win;
    logic        w_edge;
    logic [4:0]  w_cnt_next;
    logic [4:0]  w_target;
    logic        w_latch;
    logic        w_ld_move;
    logic        w_resp_ld;
    logic [7:0]  w_resp_val;
    logic        w_inc;
    logic        w_dec;
    logic        w_clr;
    logic        w_clr_cmd_rdy;
    logic        w_strt_cal;
    logic        w_fanfare;

`ifdef SQ_REPORT_EN
    assign w_cnt_win = (r_state == ST_RAMP) || (r_state == ST_REPORT);
`else
    assign w_cnt_win = (r_state == ST_RAMP);
`endif

    // Centre-line edges only count while the square counter is live.
    assign w_edge     = cntrIR & ~r_ir_prev & w_cnt_win;
    assign w_cnt_next = r_edge_cnt + {4'b0000, w_edge};
    assign w_target   = {r_sq, 1'b0};

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state  = r_state;
        w_latch       = 1'b0;
        w_ld_move     = 1'b0;
        w_resp_ld     = 1'b0;
        w_resp_val    = RESP_CMPLT;
        w_inc         = 1'b0;
        w_dec         = 1'b0;
        w_clr         = 1'b0;
        w_clr_cmd_rdy = 1'b0;
        w_strt_cal    = 1'b0;
        w_fanfare     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_rdy) begin
                    w_clr_cmd_rdy = 1'b1;
                    w_latch       = 1'b1;
                    case (cmd[15:12])
                        CMD_CAL: begin
                            w_strt_cal   = 1'b1;
                            w_next_state = ST_CAL;
                        end
                        CMD_MOVE, CMD_MOVE_FF: begin
                            w_ld_move    = 1'b1;
                            w_next_state = ST_HDG;
                        end
                        default: begin
                            w_resp_ld    = 1'b1;
                            w_resp_val   = RESP_INTER;
                            w_next_state = ST_RESP;
                        end
                    endcase
                end
            end
            ST_CAL: begin
                if (cal_done) begin
                    w_resp_ld    = 1'b1;
                    w_next_state = ST_RESP;
                end
            end
            ST_HDG: begin
                w_clr = 1'b1;
                if (at_hdg) w_next_state = ST_RAMP;
            end
            ST_RAMP: begin
                w_inc = 1'b1;
                if (w_cnt_next >= w_target) begin
                    w_next_state = ST_DECEL;
                end
`ifdef SQ_REPORT_EN
                else if (w_edge && !w_cnt_next[0]) begin
                    w_resp_ld    = 1'b1;
                    w_resp_val   = RESP_INTER;
                    w_next_state = ST_REPORT;
                end
`endif
            end
            ST_DECEL: begin
                w_dec = 1'b1;
                if (frwrd == '0) begin
                    w_fanfare    = (r_op == CMD_MOVE_FF);
                    w_resp_ld    = 1'b1;
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_sent) w_next_state = ST_IDLE;
            end
`ifdef SQ_REPORT_EN
            ST_REPORT: begin
                if (resp_sent) w_next_state = ST_RAMP;
            end
`endif
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_prev_state <= ST_IDLE;
            r_op         <= '0;
            r_sq         <= '0;
            r_edge_cnt   <= '0;
            r_ir_prev    <= 1'b0;
            r_hdg        <= '0;
            r_resp       <= '0;
        end else begin
            r_state      <= w_next_state;
            r_prev_state <= r_state;
            r_ir_prev    <= cntrIR;
            if (w_latch) begin
                r_op <= cmd[15:12];
                r_sq <= cmd[3:0];
            end
            if (w_ld_move) begin
                r_hdg      <= {cmd[11:4], 4'h0};
                r_edge_cnt <= '0;
            end else begin
                r_edge_cnt <= w_cnt_next;
            end
            if (w_resp_ld) r_resp <= w_resp_val;
        end
    end

    frwrd_ramp u_frwrd_ramp (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_inc),
        .i_dec   (w_dec),
        .i_clr   (w_clr),
        .o_frwrd (frwrd)
    );

    // A response state pulses send_resp only on the cycle it is entered.
`ifdef SQ_REPORT_EN
    assign send_resp = ((r_state == ST_RESP) || (r_state == ST_REPORT)) && (r_prev_state != r_state);
`else
    assign send_resp = (r_state == ST_RESP) && (r_prev_state != r_state);
`endif

    assign moving      = (r_state == ST_HDG) || (r_state == ST_RAMP) || (r_state == ST_DECEL);
    assign clr_cmd_rdy = w_clr_cmd_rdy;
    assign strt_cal    = w_strt_cal;
    assign fanfare     = w_fanfare;
    assign dsrd_hdg    = r_hdg;
    assign resp        = r_resp;

endmodule

// File: tb/tb_cmd_sched.sv
// Self-checking bench for cmd_sched (default build): directed test-plan commands plus
// randomized commands, judged per command against expectations computed from the move rules.
module tb_cmd_sched;

    logic        clk;
    logic        rst_n;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        strt_cal;
    logic        cal_done;
    logic [11:0] dsrd_hdg;
    logic        at_hdg;
    logic        cntrIR;
    logic [9:0]  frwrd;
    logic        moving;
    logic        fanfare;
    logic        send_resp;
    logic [7:0]  resp;
    logic        resp_sent;

    int n_vec = 0;
    int n_err = 0;

    // Monitor totals, only ever written by the monitor process.
    int         tot_clr = 0, tot_cal = 0, tot_send = 0, tot_fan = 0, tot_mov = 0, tot_bad = 0;
    logic [7:0] last_resp = '0;
    logic [9:0] fan_frwrd = '0;
    logic       fan_moving = 1'b0;
    logic [9:0] cur_peak = '0;
    logic       prev_mov = 1'b0;

    cmd_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .strt_cal    (strt_cal),
        .cal_done    (cal_done),
        .dsrd_hdg    (dsrd_hdg),
        .at_hdg      (at_hdg),
        .cntrIR      (cntrIR),
        .frwrd       (frwrd),
        .moving      (moving),
        .fanfare     (fanfare),
        .send_resp   (send_resp),
        .resp        (resp),
        .resp_sent   (resp_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (vectors %0d)", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (clr_cmd_rdy === 1'b1) tot_clr++;
        if (strt_cal === 1'b1) tot_cal++;
        if (send_resp === 1'b1) begin
            tot_send++;
            last_resp = resp;
        end
        if (fanfare === 1'b1) begin
            tot_fan++;
            fan_frwrd  = frwrd;
            fan_moving = moving;
        end
        if (moving === 1'b1) begin
            tot_mov++;
            if (prev_mov !== 1'b1 || frwrd > cur_peak) cur_peak = frwrd;
        end
        if (moving === 1'b0 && frwrd != '0) tot_bad++;
        prev_mov = moving;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_resp(input int dly, input logic [7:0] exp_resp);
        int n;
        n = 0;
        while (send_resp !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check("resp_wait_in_budget", 32'(n < 400), 32'd1);
        check("resp_byte", resp, exp_resp);
        if (dly == 0) begin
            resp_sent = 1'b1;
            tick();
            resp_sent = 1'b0;
        end else begin
            repeat (dly) tick();
            check("resp_held", resp, exp_resp);
            resp_sent = 1'b1;
            tick();
            resp_sent = 1'b0;
        end
    endtask

    // Drives one command end to end and checks the per-command totals.
    task automatic run_cmd(input logic [15:0] c, input int h_wait, input int cal_wait,
                           input int rs_dly, input int lo_max, input int hi_max);
        int         s_clr, s_cal, s_send, s_fan, s_mov, s_bad;
        int         sq, off, last, n_ramp, peak, exp_mov, exp_cal, exp_fan;
        logic [3:0] op;
        logic [7:0] exp_resp;
        logic       is_move;
        s_clr = tot_clr; s_cal = tot_cal; s_send = tot_send;
        s_fan = tot_fan; s_mov = tot_mov; s_bad = tot_bad;
        op      = c[15:12];
        sq      = int'(c[3:0]);
        is_move = (op == 4'h2) || (op == 4'h3);
        exp_mov = 0;
        exp_cal = (op == 4'h0) ? 1 : 0;
        exp_fan = (op == 4'h3) ? 1 : 0;
        peak    = 0;
        exp_resp = (op == 4'h0 || is_move) ? 8'hA5 : 8'h5A;

        cmd     = c;
        cmd_rdy = 1'b1;
        tick();
        cmd_rdy = 1'b0;

        if (op == 4'h0) begin
            repeat (cal_wait) tick();
            cal_done = 1'b1;
            tick();
            cal_done = 1'b0;
        end else if (is_move) begin
            repeat (h_wait) tick();
            check("hdg_dsrd_hdg", dsrd_hdg, {c[11:4], 4'h0});
            check("hdg_frwrd_zero", frwrd, 10'd0);
            at_hdg = 1'b1;
            tick();
            at_hdg = 1'b0;
            off  = 0;
            last = 0;
            for (int p = 0; p < 2 * sq; p++) begin
                repeat ($urandom_range(lo_max, 1)) begin
                    cntrIR = 1'b0;
                    tick();
                    off++;
                end
                cntrIR = 1'b1;
                last   = off;
                if (p != 2 * sq - 1) begin
                    repeat ($urandom_range(hi_max, 1)) begin
                        tick();
                        off++;
                    end
                end
            end
            // Speed climbs every RAMP cycle up to and including the one seeing the final edge.
            n_ramp  = (sq == 0) ? 1 : last + 1;
            peak    = (16 * n_ramp > 768) ? 768 : 16 * n_ramp;
            exp_mov = (h_wait + 1) + n_ramp + (peak + 31) / 32 + 1;
        end

        finish_resp(rs_dly, exp_resp);
        cntrIR = 1'b0;
        tick();

        check($sformatf("clr_cnt_%h", c), tot_clr - s_clr, 1);
        check($sformatf("cal_cnt_%h", c), tot_cal - s_cal, exp_cal);
        check($sformatf("send_cnt_%h", c), tot_send - s_send, 1);
        check($sformatf("fan_cnt_%h", c), tot_fan - s_fan, exp_fan);
        check($sformatf("moving_cycles_%h", c), tot_mov - s_mov, exp_mov);
        check($sformatf("idle_speed_%h", c), tot_bad - s_bad, 0);
        check($sformatf("back_idle_%h", c), {moving, send_resp}, 2'b00);
        if (is_move) begin
            check($sformatf("peak_%h", c), cur_peak, peak);
            check($sformatf("hdg_hold_%h", c), dsrd_hdg, {c[11:4], 4'h0});
        end
        if (op == 4'h3) begin
            check("fanfare_at_zero", fan_frwrd, 10'd0);
            check("fanfare_in_motion", fan_moving, 1'b1);
        end
    endtask

    initial begin
        int         n, s_send;
        logic [3:0] op;
        int         pick;
        rst_n     = 1'b0;
        cmd       = '0;
        cmd_rdy   = 1'b0;
        cal_done  = 1'b0;
        at_hdg    = 1'b0;
        cntrIR    = 1'b0;
        resp_sent = 1'b0;
        repeat (3) tick();
        check("rst_frwrd", frwrd, 10'd0);
        check("rst_dsrd_hdg", dsrd_hdg, 12'd0);
        check("rst_resp", resp, 8'h00);
        check("rst_pulses", {clr_cmd_rdy, strt_cal, fanfare, send_resp}, 4'b0000);
        check("rst_moving", moving, 1'b0);
        rst_n = 1'b1;
        tick();

        // Directed test-plan commands.
        run_cmd(16'h0000, 0, 50, 1, 1, 1);
        run_cmd(16'h2FF2, 20, 0, 0, 3, 3);
        run_cmd(16'h3003, 2, 0, 2, 2, 2);
        run_cmd(16'h7000, 0, 0, 0, 1, 1);
        run_cmd(16'h2005, 0, 0, 1, 2, 2);
        run_cmd(16'h3100, 1, 0, 3, 1, 1);

        // Reset in the middle of RAMP with frwrd at 0x150.
        s_send  = tot_send;
        cmd     = 16'h2FF2;
        cmd_rdy = 1'b1;
        tick();
        cmd_rdy = 1'b0;
        at_hdg  = 1'b1;
        tick();
        at_hdg  = 1'b0;
        n = 0;
        while (frwrd !== 10'h150 && n < 200) begin
            tick();
            n++;
        end
        check("ramp_reach_150", 32'(n < 200), 32'd1);
        rst_n = 1'b0;
        tick();
        check("midrst_frwrd", frwrd, 10'd0);
        check("midrst_moving", moving, 1'b0);
        check("midrst_hdg", dsrd_hdg, 12'd0);
        check("midrst_resp", resp, 8'h00);
        rst_n = 1'b1;
        repeat (5) tick();
        check("midrst_no_send", tot_send - s_send, 0);
        run_cmd(16'h0000, 0, 7, 0, 1, 1);

        // Randomized commands.
        for (int k = 0; k < 16; k++) begin
            pick = $urandom_range(3, 0);
            case (pick)
                0: op = 4'h0;
                1: op = 4'h2;
                2: op = 4'h3;
                default: begin
                    n  = $urandom_range(16, 4);
                    op = (n == 16) ? 4'h1 : 4'(n);
                end
            endcase
            run_cmd({op, 8'($urandom_range(255, 0)), 4'($urandom_range(6, 0))},
                    $urandom_range(10, 0), $urandom_range(20, 1), $urandom_range(3, 0),
                    $urandom_range(4, 1), $urandom_range(4, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
